// File: rtl/nios2_jtag_dbg_pkg.sv
// rtl/nios2_jtag_dbg_pkg.sv - shared types and constants for the Nios II JTAG debug bridge
package nios2_jtag_dbg_pkg;

    localparam int DEF_IR_W = 2;
    localparam int DEF_DR_W = 38;

    localparam logic [1:0] IR_OCIMEM    = 2'd0;
    localparam logic [1:0] IR_TRACEMEM  = 2'd1;
    localparam logic [1:0] IR_BREAK     = 2'd2;
    localparam logic [1:0] IR_TRACECTRL = 2'd3;

    localparam int SYNC_STAGES_MIN = 2;
    localparam int SYNC_STAGES_MAX = 4;

    typedef struct packed {
        logic                uir;
        logic [DEF_IR_W-1:0] ir;
        logic [DEF_DR_W-1:0] data;
    } cmd_entry_t;

    // Out-of-range synchroniser depths are pulled back into the legal window.
    function automatic int sync_stages_checked(input int n);
        if (n < SYNC_STAGES_MIN) return SYNC_STAGES_MIN;
        if (n > SYNC_STAGES_MAX) return SYNC_STAGES_MAX;
        return n;
    endfunction

endpackage

// File: rtl/nios2_jtag_sync_edge.sv
// rtl/nios2_jtag_sync_edge.sv - strobe synchroniser with one-cycle rising-edge pulse
module nios2_jtag_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic level,
    output logic pulse
);

    logic [STAGES-1:0] sync;
    logic              prev;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync <= '0;
            prev <= 1'b0;
        end else begin
            sync <= {sync[STAGES-2:0], level};
            prev <= sync[STAGES-1];
        end
    end

    assign pulse = sync[STAGES-1] & ~prev;

endmodule

// File: rtl/nios2_jtag_sysclk_cmd_bridge.sv
// rtl/nios2_jtag_sysclk_cmd_bridge.sv - clk-domain capture and queueing of JTAG update events
module nios2_jtag_sysclk_cmd_bridge
    import nios2_jtag_dbg_pkg::*;
#(
    parameter int IR_W        = DEF_IR_W,
    parameter int DR_W        = DEF_DR_W,
    parameter int SYNC_STAGES = 2,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic [IR_W-1:0]                 ir_in,
    input  logic [DR_W-1:0]                 sr,
    input  logic                            vs_udr,
    input  logic                            vs_uir,
    output logic                            cmd_valid,
    input  logic                            cmd_ready,
    output logic                            cmd_uir,
    output logic [IR_W-1:0]                 cmd_ir,
    output logic [DR_W-1:0]                 cmd_data,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level,
    output logic                            overflow,
    input  logic                            overflow_clr
);

    localparam int SYNC_N  = sync_stages_checked(SYNC_STAGES);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int LVL_W   = $clog2(FIFO_DEPTH + 1);
    localparam int ARM_MAX = SYNC_N + 1;

    typedef struct packed {
        logic            uir;
        logic [IR_W-1:0] ir;
        logic [DR_W-1:0] data;
    } entry_t;

    entry_t            mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [2:0]        arm_cnt;
    logic              armed;
    logic              dr_pulse;
    logic              ir_pulse;
    logic              dr_ev;
    logic              ir_ev;
    logic              pend;
    logic [IR_W-1:0]   pend_ir;
    logic              pend_next;
    logic [IR_W-1:0]   pend_ir_next;
    logic              push_req;
    logic              push_ok;
    entry_t            push_entry;
    logic              drop;
    logic              full;
    logic              pop;
    logic              ovf_set;
    logic [LVL_W-1:0]  level_next;

    nios2_jtag_sync_edge #(.STAGES(SYNC_N)) u_sync_udr (
        .clk     (clk),
        .reset_n (reset_n),
        .level   (vs_udr),
        .pulse   (dr_pulse)
    );

    nios2_jtag_sync_edge #(.STAGES(SYNC_N)) u_sync_uir (
        .clk     (clk),
        .reset_n (reset_n),
        .level   (vs_uir),
        .pulse   (ir_pulse)
    );

    // The sync chains run during the arm window, so a strobe already high at release never fires.
    assign armed = (arm_cnt == 3'(ARM_MAX));
    assign dr_ev = armed & dr_pulse;
    assign ir_ev = armed & ir_pulse;

    always_comb begin
        push_req     = 1'b0;
        push_entry   = '0;
        pend_next    = pend;
        pend_ir_next = pend_ir;
        drop         = 1'b0;
        if (dr_ev) begin
            push_req        = 1'b1;
            push_entry.uir  = 1'b0;
            push_entry.ir   = ir_in;
            push_entry.data = sr;
            if (ir_ev) begin
                if (pend) begin
                    drop = 1'b1;
                end else begin
                    pend_next    = 1'b1;
                    pend_ir_next = ir_in;
                end
            end
        end else if (pend) begin
            push_req       = 1'b1;
            push_entry.uir = 1'b1;
            push_entry.ir  = pend_ir;
            pend_next      = 1'b0;
            drop           = ir_ev;
        end else if (ir_ev) begin
            push_req       = 1'b1;
            push_entry.uir = 1'b1;
            push_entry.ir  = ir_in;
        end
    end

    assign full       = (fifo_level == LVL_W'(FIFO_DEPTH));
    assign pop        = cmd_valid & cmd_ready;
    assign push_ok    = push_req & (~full | pop);
    assign ovf_set    = drop | (push_req & ~push_ok);
    assign level_next = fifo_level + LVL_W'(push_ok) - LVL_W'(pop);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            cmd_valid  <= 1'b0;
            overflow   <= 1'b0;
            pend       <= 1'b0;
            pend_ir    <= '0;
            arm_cnt    <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            fifo_level <= level_next;
            cmd_valid  <= (level_next != '0);
            overflow   <= ovf_set | (overflow & ~overflow_clr);
            pend       <= pend_next;
            pend_ir    <= pend_ir_next;
            if (!armed) arm_cnt <= arm_cnt + 3'd1;
        end
    end

    // Storage is cleared on reset so the head reads as all-zero while the queue is empty.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else if (push_ok) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    assign cmd_uir  = mem[rd_ptr].uir;
    assign cmd_ir   = mem[rd_ptr].ir;
    assign cmd_data = mem[rd_ptr].data;

endmodule

// File: tb/tb_nios2_jtag_sysclk_cmd_bridge.sv
// tb/tb_nios2_jtag_sysclk_cmd_bridge.sv - directed self-checking bench for the JTAG command bridge
module tb_nios2_jtag_sysclk_cmd_bridge;
    import nios2_jtag_dbg_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  ir_in = '0;
    logic [37:0] sr = '0;
    logic        vs_udr = 1'b0;
    logic        vs_uir = 1'b0;
    logic        cmd_valid;
    logic        cmd_ready = 1'b0;
    logic        cmd_uir;
    logic [1:0]  cmd_ir;
    logic [37:0] cmd_data;
    logic [2:0]  fifo_level;
    logic        overflow;
    logic        overflow_clr = 1'b0;

    int checks = 0;
    int failures = 0;

    logic [37:0] d [6];
    logic [37:0] exp_order [4];

    always #5 clk = ~clk;

    nios2_jtag_sysclk_cmd_bridge #(
        .IR_W(2), .DR_W(38), .SYNC_STAGES(2), .FIFO_DEPTH(4)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .ir_in        (ir_in),
        .sr           (sr),
        .vs_udr       (vs_udr),
        .vs_uir       (vs_uir),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_uir      (cmd_uir),
        .cmd_ir       (cmd_ir),
        .cmd_data     (cmd_data),
        .fifo_level   (fifo_level),
        .overflow     (overflow),
        .overflow_clr (overflow_clr)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) step();
    endtask

    task automatic dr_pulse(input logic [1:0] ir_val, input logic [37:0] sr_val);
        ir_in  = ir_val;
        sr     = sr_val;
        vs_udr = 1'b1;
        step();
        step();
        vs_udr = 1'b0;
        step();
        step();
    endtask

    initial begin
        d[0] = 38'h01_0000_0001;
        d[1] = 38'h02_2222_2222;
        d[2] = 38'h03_3333_3333;
        d[3] = 38'h04_4444_4444;
        d[4] = 38'h05_5555_5555;
        d[5] = 38'h06_6666_6666;

        // reset values, strobe held high through release
        vs_udr = 1'b1;
        step();
        check("rst_valid", 64'(cmd_valid), 64'd0);
        check("rst_level", 64'(fifo_level), 64'd0);
        check("rst_data", 64'(cmd_data), 64'd0);
        check("rst_ovf", 64'(overflow), 64'd0);
        do_reset();
        step();
        vs_udr = 1'b0;
        step();
        step();
        check("held_valid", 64'(cmd_valid), 64'd0);
        check("held_level", 64'(fifo_level), 64'd0);

        // single DR event latency and capture
        ir_in  = IR_BREAK;
        sr     = 38'h15_5555_5555;
        vs_udr = 1'b1;
        step();
        check("lat_k", 64'(cmd_valid), 64'd0);
        step();
        check("lat_k1", 64'(cmd_valid), 64'd0);
        step();
        check("lat_k2", 64'(cmd_valid), 64'd1);
        step();
        vs_udr = 1'b0;
        step();
        step();
        check("dr_uir", 64'(cmd_uir), 64'd0);
        check("dr_ir", 64'(cmd_ir), 64'd2);
        check("dr_data", 64'(cmd_data), 64'h15_5555_5555);
        check("dr_level", 64'(fifo_level), 64'd1);

        // simultaneous DR and IR events
        do_reset();
        ir_in  = IR_TRACEMEM;
        sr     = 38'h2A_0F0F_0F0F;
        vs_udr = 1'b1;
        vs_uir = 1'b1;
        step();
        step();
        step();
        check("both_lvl1", 64'(fifo_level), 64'd1);
        step();
        check("both_lvl2", 64'(fifo_level), 64'd2);
        vs_udr = 1'b0;
        vs_uir = 1'b0;
        step();
        check("both_hd_uir", 64'(cmd_uir), 64'd0);
        check("both_hd_ir", 64'(cmd_ir), 64'd1);
        check("both_hd_data", 64'(cmd_data), 64'h2A_0F0F_0F0F);
        cmd_ready = 1'b1;
        step();
        cmd_ready = 1'b0;
        check("both_ir_uir", 64'(cmd_uir), 64'd1);
        check("both_ir_ir", 64'(cmd_ir), 64'd1);
        check("both_ir_data", 64'(cmd_data), 64'd0);
        check("both_ir_lvl", 64'(fifo_level), 64'd1);

        // overflow on a full queue, then clear
        do_reset();
        for (int i = 0; i < 5; i++) dr_pulse(IR_OCIMEM, d[i]);
        check("ovf_level", 64'(fifo_level), 64'd4);
        check("ovf_flag", 64'(overflow), 64'd1);
        check("ovf_head", 64'(cmd_data), 64'(d[0]));
        overflow_clr = 1'b1;
        step();
        overflow_clr = 1'b0;
        check("ovf_clr", 64'(overflow), 64'd0);

        // push into a full queue while popping is accepted
        sr     = d[5];
        vs_udr = 1'b1;
        step();
        step();
        vs_udr = 1'b0;
        cmd_ready = 1'b1;
        step();
        cmd_ready = 1'b0;
        check("pp_level", 64'(fifo_level), 64'd4);
        check("pp_ovf", 64'(overflow), 64'd0);
        step();
        exp_order[0] = d[1];
        exp_order[1] = d[2];
        exp_order[2] = d[3];
        exp_order[3] = d[5];
        for (int i = 0; i < 4; i++) begin
            check($sformatf("order%0d", i), 64'(cmd_data), 64'(exp_order[i]));
            cmd_ready = 1'b1;
            step();
            cmd_ready = 1'b0;
        end
        check("drain_valid", 64'(cmd_valid), 64'd0);
        check("drain_level", 64'(fifo_level), 64'd0);

        // asynchronous reset with entries queued
        do_reset();
        for (int i = 0; i < 3; i++) dr_pulse(IR_TRACECTRL, d[i]);
        check("q3_level", 64'(fifo_level), 64'd3);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_valid", 64'(cmd_valid), 64'd0);
        check("arst_level", 64'(fifo_level), 64'd0);
        check("arst_data", 64'(cmd_data), 64'd0);
        check("arst_ir", 64'(cmd_ir), 64'd0);
        step();
        reset_n = 1'b1;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
